// File: rtl/ct_f_spsram_cfg_pkg.sv
// Shared types for the configurable single-port SRAM wrapper.
// Holds the sequencer state encoding and the read-latency helper.
package ct_f_spsram_cfg_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Cycles from a sampled read to Q/RD_VLD for a given RD_PIPE setting.
  function automatic int unsigned rd_latency(input int unsigned rd_pipe);
    return (rd_pipe != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/ct_f_spsram_cfg_array.sv
// Behavioural 1R/1W RAM with per-bit active-high write mask and synchronous read.
// A write commits on the edge, so a read on the next edge sees the new word.
module ct_f_spsram_cfg_array #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] wr_word_c;

  always_comb begin
    wr_word_c = (mem_q[addr] & ~wmask) | (wdata & wmask);
    rdata_d   = rdata_q;
    if (ce && !we) begin
      rdata_d = mem_q[addr];
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      mem_q[addr] <= wr_word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ct_f_spsram_cfg.sv
// Configurable single-port SRAM wrapper: post-reset zero-fill, bit-masked writes,
// address holding while deselected, optional output register and read-valid strobe.
module ct_f_spsram_cfg
  import ct_f_spsram_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RD_PIPE    = 0,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  RD_VLD,
  output logic                  INIT_DONE
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned RD_LAT = rd_latency(RD_PIPE);
  localparam state_e      RST_ST = (INIT_EN != 0) ? ST_INIT : ST_START;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_vld1_q, rd_vld1_d;

  logic                  init_c, port_rd_c, port_wr_c;
  logic                  arr_ce_c, arr_we_c;
  logic [DATA_WIDTH-1:0] arr_mask_c, arr_wdata_c, arr_rdata;
  logic [ADDR_WIDTH-1:0] arr_addr_c;

  // Sequencer: zero-fill walks every address once, then parks in READY.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = (state_q == ST_READY);
    case (state_q)
      ST_START: state_d = ST_READY;
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = RST_ST;
    endcase
  end

  // Ports are only honoured once INIT_DONE is visible to the requester.
  always_comb begin
    init_c      = (state_q == ST_INIT);
    port_rd_c   = init_done_q && !CEN && GWEN;
    port_wr_c   = init_done_q && !CEN && !GWEN;
    addr_hold_d = CEN ? addr_hold_q : A;
    rd_vld1_d   = port_rd_c;
    arr_ce_c    = init_c || port_rd_c || port_wr_c;
    arr_we_c    = init_c || port_wr_c;
    arr_mask_c  = init_c ? '1 : ~WEN;
    arr_wdata_c = init_c ? '0 : D;
    arr_addr_c  = init_c ? cnt_q[ADDR_WIDTH-1:0] : (!CEN ? A : addr_hold_q);
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= RST_ST;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      init_done_q <= 1'b0;
      rd_vld1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      init_done_q <= init_done_d;
      rd_vld1_q   <= rd_vld1_d;
    end
  end

  ct_f_spsram_cfg_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (CLK),
    .rst_n(cpurst_b),
    .ce   (arr_ce_c),
    .we   (arr_we_c),
    .wmask(arr_mask_c),
    .addr (arr_addr_c),
    .wdata(arr_wdata_c),
    .rdata(arr_rdata)
  );

  if (RD_LAT == 2) begin : g_pipe
    logic [DATA_WIDTH-1:0] q_pipe_q, q_pipe_d;
    logic                  rd_vld2_q;

    always_comb q_pipe_d = rd_vld1_q ? arr_rdata : q_pipe_q;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        q_pipe_q  <= '0;
        rd_vld2_q <= 1'b0;
      end else begin
        q_pipe_q  <= q_pipe_d;
        rd_vld2_q <= rd_vld1_q;
      end
    end

    assign Q      = q_pipe_q;
    assign RD_VLD = rd_vld2_q;
  end else begin : g_nopipe
    assign Q      = arr_rdata;
    assign RD_VLD = rd_vld1_q;
  end

  assign INIT_DONE = init_done_q;

endmodule
